uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 115 +++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO, paced by an external
// oversampling strobe (OVERSAMPLE ticks per bit).
module uart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_x16,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          tx_next;
    logic          push, pop, bit_end;

    // Handshake: a byte transfers on any rising edge where in_valid and
    // in_ready are both high; in_ready depends only on the registered count.
    assign in_ready   = (count != COUNT_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);
    assign bit_end    = tick_x16 && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (count != '0) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // shift[0] always holds the bit on the line during DATA, so the next bit is shift[1].
    always_comb begin
        pop     = 1'b0;
        tx_next = tx;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (count != '0) begin
                    pop     = 1'b1;
                    tx_next = 1'b0;
                end
            end
            START: if (bit_end) tx_next = shift[0];
            DATA:  if (bit_end) tx_next = (bit_cnt == 3'd7) ? 1'b1 : shift[1];
            STOP:  tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            tx <= tx_next;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                shift    <= mem[rptr];
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != IDLE && tick_x16) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
                if (state == DATA && bit_end) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shift   <= shift >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame timing, back-to-back frames, FIFO full,
// slow tick rate and mid-frame reset.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_x16 = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx, busy;
    logic [2:0] fifo_count;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tick_div = 1;
    logic tick_en = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick_x16(tick_x16),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // tick_x16 changes 1 time unit after each rising edge
    initial begin : tick_gen
        int dc;
        dc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                tick_x16 = (dc == 0);
                dc = (dc >= tick_div - 1) ? 0 : dc + 1;
            end else begin
                tick_x16 = 1'b0;
                dc = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push_byte(input logic [7:0] d, output logic acc);
        in_valid = 1'b1;
        in_data  = d;
        acc      = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic wait_low(input string tag, output int t);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx, 1'b0);
        t = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic measure_run(input logic lvl, output int len);
        len = 0;
        while (tx === lvl && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic rx_byte(input string tag, output logic [7:0] b, output int t);
        int bit_clks;
        bit_clks = 16 * tick_div;
        b = 8'h00;
        wait_low({tag, "_start_timeout"}, t);
        repeat (bit_clks / 2) @(negedge clk);
        check({tag, "_start_bit"}, tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (bit_clks) @(negedge clk);
            b[i] = tx;
        end
        repeat (bit_clks) @(negedge clk);
        check({tag, "_stop_bit"}, tx, 1'b1);
    endtask

    initial begin : main
        logic       acc;
        logic [7:0] b;
        logic [7:0] exp_b;
        int         t0, t1, len, lows;
        logic [7:0] t3_bytes [6];

        t3_bytes[0] = 8'h11; t3_bytes[1] = 8'h22; t3_bytes[2] = 8'h33;
        t3_bytes[3] = 8'h44; t3_bytes[4] = 8'h55; t3_bytes[5] = 8'h66;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fifo_count", fifo_count, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x55 at one tick per clk: 16-clk runs, busy for 160 clks from start
        tick_div = 1;
        tick_en  = 1'b1;
        push_byte(8'h55, acc);
        check("t1_accept", acc, 1'b1);
        check("t1_count", fifo_count, 3'd1);
        check("t1_busy", busy, 1'b1);
        wait_low("t1_start_timeout", t0);
        for (int r = 0; r < 9; r++) begin
            measure_run(r[0], len);
            check($sformatf("t1_run%0d", r), len, 16);
        end
        len = 0;
        while (busy !== 1'b0 && len < 1000) begin
            @(negedge clk);
            len++;
        end
        check("t1_busy_len", cyc - t0, 160);
        wait_idle("t1_idle");

        // back-to-back 0xA5, 0x3C with a single idle clk between frames
        push_byte(8'hA5, acc);
        check("t2_accept0", acc, 1'b1);
        exp_q.push_back(8'hA5);
        push_byte(8'h3C, acc);
        check("t2_accept1", acc, 1'b1);
        exp_q.push_back(8'h3C);
        check("t2_count", fifo_count, 3'd1);
        rx_byte("t2_f0", b, t0);
        exp_b = exp_q.pop_front();
        check("t2_byte0", b, exp_b);
        rx_byte("t2_f1", b, t1);
        exp_b = exp_q.pop_front();
        check("t2_byte1", b, exp_b);
        check("t2_start_spacing", t1 - t0, 161);
        wait_idle("t2_idle");

        // tick held low: one pops, four queue, sixth refused
        tick_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            push_byte(t3_bytes[i], acc);
            check($sformatf("t3_accept%0d", i), acc, 1'b1);
            exp_q.push_back(t3_bytes[i]);
            check($sformatf("t3_count%0d", i), fifo_count, (i == 0) ? 3'd1 : 3'(i));
        end
        check("t3_full_ready", in_ready, 1'b0);
        check("t3_full_count", fifo_count, 3'd4);
        push_byte(t3_bytes[5], acc);
        check("t3_accept5", acc, 1'b0);
        check("t3_count_after_refuse", fifo_count, 3'd4);
        repeat (20) @(negedge clk);
        check("t3_tx_hold", tx, 1'b0);
        check("t3_busy_hold", busy, 1'b1);
        tick_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_byte($sformatf("t3_f%0d", i), b, t0);
            exp_b = exp_q.pop_front();
            check($sformatf("t3_byte%0d", i), b, exp_b);
        end
        wait_idle("t3_idle");

        // one tick every 7 clks: 0x81 data runs are 112 and 6*112 clks
        tick_en  = 1'b0;
        tick_div = 7;
        @(negedge clk);
        tick_en = 1'b1;
        push_byte(8'h81, acc);
        check("t4_accept", acc, 1'b1);
        wait_low("t4_start_timeout", t0);
        measure_run(1'b0, len);
        measure_run(1'b1, len);
        check("t4_bit0_len", len, 112);
        measure_run(1'b0, len);
        check("t4_zero_run_len", len, 672);
        check("t4_bit7", tx, 1'b1);
        wait_idle("t4_idle");

        // reset during data bit 3 of 0xF0 with two bytes queued
        tick_en  = 1'b0;
        tick_div = 1;
        @(negedge clk);
        tick_en = 1'b1;
        push_byte(8'hF0, acc);
        wait_low("t5_start_timeout", t0);
        push_byte(8'h01, acc);
        push_byte(8'h02, acc);
        len = 0;
        while (cyc - t0 < 72 && len < 200) begin
            @(negedge clk);
            len++;
        end
        check("t5_pre_tx", tx, 1'b0);
        check("t5_pre_count", fifo_count, 3'd2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1'b1);
        check("t5_rst_count", fifo_count, 3'd0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t5_no_frames", lows, 0);
        check("t5_busy_after", busy, 1'b0);

        // push accepted on the first edge after reset release
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_byte(8'hC3, acc);
        check("t6_accept", acc, 1'b1);
        check("t6_count", fifo_count, 3'd1);
        rx_byte("t6_f0", b, t0);
        check("t6_byte", b, 8'hC3);
        wait_idle("t6_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
